// File: rtl/config_pkg.sv
// Build-configuration package: the subset of the core configuration that the
// PMA region table reads (physical address width and the reset region rules).
// Ports: none (types and constants only).
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                  PLEN;
    int unsigned                  NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentLength;
    int unsigned                  NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]  ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  ExecuteRegionLength;
    int unsigned                  NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]  CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  CachedRegionLength;
  } cva6_cfg_t;

  // No region rules at all; only the address width is meaningful.
  function automatic cva6_cfg_t empty_cfg();
    cva6_cfg_t cfg;
    cfg      = '0;
    cfg.PLEN = 56;
    return cfg;
  endfunction

  localparam cva6_cfg_t cva6_cfg_empty = empty_cfg();

endpackage

// File: rtl/pma_pkg.sv
// Shared types for the PMA region table: attribute classes, register field
// map, lookup result and stored rule format.
// Ports: none (types and constants only).
package pma_pkg;

  localparam int unsigned NrClasses = 3;

  typedef enum logic [1:0] {
    NONIDEM = 2'd0,
    EXEC    = 2'd1,
    CACHED  = 2'd2
  } pma_class_e;

  // Field code 3 is reserved and rejected by the register port.
  typedef enum logic [1:0] {
    BASE = 2'd0,
    LEN  = 2'd1,
    CTRL = 2'd2
  } pma_field_e;

  typedef struct packed {
    logic cached;
    logic exec;
    logic nonidem;
  } pma_attr_t;

  // base is held in 64 bits but is always zero-extended from the physical
  // address width, so wide compares need no further masking.
  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
    logic        en;
    logic        lock;
  } pma_rule_t;

endpackage

// File: rtl/pma_region_table_if.sv
// Bus bundle of the PMA region table: register access port plus the parallel
// lookup ports. slave = the table, master = the requester.
// Signals: cfg_{req,we,addr,wdata}_i / cfg_{gnt,rvalid,rdata,err}_o,
//          lookup_{valid,addr}_i / lookup_{valid,attr}_o.
interface pma_region_table_if
  import pma_pkg::*;
#(
  parameter int unsigned CfgAddrWidth = 7,
  parameter int unsigned NrPorts      = 2,
  parameter int unsigned AddrWidth    = 56
) ();

  logic                               cfg_req_i;
  logic                               cfg_we_i;
  logic [CfgAddrWidth-1:0]            cfg_addr_i;
  logic [63:0]                        cfg_wdata_i;
  logic                               cfg_gnt_o;
  logic                               cfg_rvalid_o;
  logic [63:0]                        cfg_rdata_o;
  logic                               cfg_err_o;

  logic [NrPorts-1:0]                 lookup_valid_i;
  logic [NrPorts-1:0][AddrWidth-1:0]  lookup_addr_i;
  logic [NrPorts-1:0]                 lookup_valid_o;
  pma_attr_t [NrPorts-1:0]            lookup_attr_o;

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    input  lookup_valid_i, lookup_addr_i,
    output lookup_valid_o, lookup_attr_o
  );

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    output lookup_valid_i, lookup_addr_i,
    input  lookup_valid_o, lookup_attr_o
  );

endinterface

// File: rtl/pma_rule_match.sv
// Single-rule address comparator: hit when enabled and base <= addr < base+len.
// Latency: combinational. Backpressure: none.
// Ports: addr_i/base_i/len_i (64-bit, zero-extended), en_i -> match_o.
module pma_rule_match (
  input  logic [63:0] addr_i,
  input  logic [63:0] base_i,
  input  logic [63:0] len_i,
  input  logic        en_i,
  output logic        match_o
);

  logic [63:0] offset;

  // Comparing the offset instead of addr < base+len avoids the wrap when a
  // region runs past the top of the address space; len==0 can never match.
  assign offset  = addr_i - base_i;
  assign match_o = en_i && (addr_i >= base_i) && (offset < len_i);

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table: NrRules entries per class (non-idempotent,
// executable, cached), reprogrammable via a register port, NrPorts lookups.
// Latency: lookup and register response both 1 cycle. Backpressure: none,
// every request is accepted in the cycle it is presented (gnt = req).
// Ports: clk_i, rst_i (sync, active high), bus (slave), table_update_o.
module pma_region_table
  import pma_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NrRules   = 8,
  parameter int unsigned           NrPorts   = 2,
  parameter int unsigned           AddrWidth = CVA6Cfg.PLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pma_region_table_if.slave bus,
  output logic              table_update_o
);

  localparam int unsigned RuleW    = (NrRules > 1) ? $clog2(NrRules) : 1;
  localparam int unsigned RuleSpan = 2 ** RuleW;
  localparam int unsigned CfgIdxW  = $clog2(config_pkg::NrMaxRules);
  localparam logic [63:0] AddrMask = (AddrWidth >= 64) ? {64{1'b1}}
                                                       : ((64'd1 << AddrWidth) - 64'd1);
  // Bit i set when rule index i exists; indexes beyond NrRules are decoded
  // errors rather than aliases.
  localparam logic [RuleSpan-1:0] RuleOk = {RuleSpan{1'b1}} >> (RuleSpan - NrRules);

  function automatic pma_rule_t reset_rule(input int unsigned cls, input int unsigned idx);
    pma_rule_t            rule;
    int unsigned          nr;
    logic [63:0]          base;
    logic [63:0]          len;
    logic [CfgIdxW-1:0]   i;
    i    = idx[CfgIdxW-1:0];
    rule = '0;
    case (cls)
      0: begin
        nr   = CVA6Cfg.NrNonIdempotentRules;
        base = CVA6Cfg.NonIdempotentAddrBase[i];
        len  = CVA6Cfg.NonIdempotentLength[i];
      end
      1: begin
        nr   = CVA6Cfg.NrExecuteRegionRules;
        base = CVA6Cfg.ExecuteRegionAddrBase[i];
        len  = CVA6Cfg.ExecuteRegionLength[i];
      end
      default: begin
        nr   = CVA6Cfg.NrCachedRegionRules;
        base = CVA6Cfg.CachedRegionAddrBase[i];
        len  = CVA6Cfg.CachedRegionLength[i];
      end
    endcase
    if (idx < nr && len != 64'd0) begin
      rule.base = base & AddrMask;
      rule.len  = len;
      rule.en   = 1'b1;
    end
    return rule;
  endfunction

  pma_rule_t rules_q [NrClasses][NrRules];
  pma_rule_t rules_d [NrClasses][NrRules];

  // ---------------------------------------------------------------------------
  // Register port decode: cfg_addr = {class, rule, field}
  // ---------------------------------------------------------------------------
  logic [1:0]        cls;
  logic [RuleW-1:0]  ridx;
  logic [1:0]        fld;
  logic              addr_bad;
  logic [1:0]        cls_s;
  logic [RuleW-1:0]  ridx_s;

  assign cls      = bus.cfg_addr_i[RuleW+3:RuleW+2];
  assign ridx     = bus.cfg_addr_i[RuleW+1:2];
  assign fld      = bus.cfg_addr_i[1:0];
  assign addr_bad = (cls == 2'd3) || (fld == 2'd3) || !RuleOk[ridx];
  // Safe indices keep the array reads in range on a bad address.
  assign cls_s    = addr_bad ? 2'd0 : cls;
  assign ridx_s   = addr_bad ? '0 : ridx;

  pma_rule_t   cur;
  pma_rule_t   nxt;
  logic        wr_err;
  logic        changed;
  logic        do_write;
  logic [63:0] rd_data;

  always_comb begin
    rules_d = rules_q;
    cur     = rules_q[cls_s][ridx_s];
    nxt     = cur;
    wr_err  = 1'b0;
    rd_data = '0;

    // Lock guards every field; base/len additionally require en=0 so that a
    // region is never observed half-moved.
    if (addr_bad || cur.lock) begin
      wr_err = 1'b1;
    end else begin
      case (fld)
        BASE: begin
          if (cur.en) wr_err = 1'b1;
          else        nxt.base = bus.cfg_wdata_i & AddrMask;
        end
        LEN: begin
          if (cur.en) wr_err = 1'b1;
          else        nxt.len = bus.cfg_wdata_i;
        end
        default: begin
          nxt.en   = bus.cfg_wdata_i[0];
          nxt.lock = bus.cfg_wdata_i[1];
        end
      endcase
    end

    // Setting only the lock bit does not alter matching, so it does not count.
    changed  = (nxt.base != cur.base) || (nxt.len != cur.len) || (nxt.en != cur.en);
    do_write = bus.cfg_req_i && bus.cfg_we_i && !wr_err;
    if (do_write) rules_d[cls_s][ridx_s] = nxt;

    case (fld)
      BASE:    rd_data = cur.base;
      LEN:     rd_data = cur.len;
      default: rd_data = {62'd0, cur.lock, cur.en};
    endcase
    if (addr_bad) rd_data = '0;
  end

  logic        rvalid_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        update_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
      for (int unsigned c = 0; c < NrClasses; c++) begin
        for (int unsigned r = 0; r < NrRules; r++) begin
          rules_q[c][r] <= reset_rule(c, r);
        end
      end
    end else begin
      rvalid_q <= bus.cfg_req_i;
      rdata_q  <= (bus.cfg_req_i && !bus.cfg_we_i) ? rd_data : 64'd0;
      err_q    <= bus.cfg_req_i && (bus.cfg_we_i ? wr_err : addr_bad);
      update_q <= do_write && changed;
      rules_q  <= rules_d;
    end
  end

  assign bus.cfg_gnt_o    = bus.cfg_req_i;
  assign bus.cfg_rvalid_o = rvalid_q;
  assign bus.cfg_rdata_o  = rdata_q;
  assign bus.cfg_err_o    = err_q;
  assign table_update_o   = update_q;

  // ---------------------------------------------------------------------------
  // Lookup ports: compare against the registered table, so a write in the
  // same cycle is only visible to the following cycle's lookups.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic [63:0]                       addr64;
    logic [NrClasses-1:0][NrRules-1:0] hit;
    pma_attr_t                         attr_d;
    pma_attr_t                         attr_q;
    logic                              valid_q;

    assign addr64 = 64'(bus.lookup_addr_i[p]);

    for (genvar c = 0; c < NrClasses; c++) begin : g_class
      for (genvar r = 0; r < NrRules; r++) begin : g_rule
        pma_rule_match u_match (
          .addr_i  (addr64),
          .base_i  (rules_q[c][r].base),
          .len_i   (rules_q[c][r].len),
          .en_i    (rules_q[c][r].en),
          .match_o (hit[c][r])
        );
      end
    end

    assign attr_d = {|hit[2], |hit[1], |hit[0]};

    // attr holds its last value while no request is made on the port.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        attr_q  <= '0;
      end else begin
        valid_q <= bus.lookup_valid_i[p];
        if (bus.lookup_valid_i[p]) attr_q <= attr_d;
      end
    end

    assign bus.lookup_valid_o[p] = valid_q;
    assign bus.lookup_attr_o[p]  = attr_q;
  end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table: reset contents, lookup boundaries,
// write protection, lock, same-cycle write/lookup ordering and mid-run reset.
module tb_pma_region_table;
  import pma_pkg::*;

  localparam int unsigned NR = 6;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 34;
  localparam int unsigned CW = 4 + $clog2(NR);

  function automatic config_pkg::cva6_cfg_t tb_cfg();
    config_pkg::cva6_cfg_t c;
    c = config_pkg::cva6_cfg_empty;
    c.PLEN                     = AW;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h8000_0000;
    c.NrExecuteRegionRules     = 2;
    c.ExecuteRegionAddrBase[0] = 64'h8000_0000;
    c.ExecuteRegionLength[0]   = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h3_FFFF_F000;
    c.ExecuteRegionLength[1]   = 64'h1_0000;
    c.NrCachedRegionRules      = 2;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.CachedRegionAddrBase[1]  = 64'h1000;
    c.CachedRegionLength[1]    = 64'h0;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t TbCfg = tb_cfg();

  logic clk = 1'b0;
  logic rst;
  logic table_update;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pma_region_table_if #(.CfgAddrWidth(CW), .NrPorts(NP), .AddrWidth(AW)) bus ();

  pma_region_table #(
    .CVA6Cfg   (TbCfg),
    .NrRules   (NR),
    .NrPorts   (NP),
    .AddrWidth (AW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .table_update_o (table_update)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_op(input string tag, input logic we, input logic [1:0] cls,
                        input logic [2:0] rule, input logic [1:0] fld, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err, input logic exp_upd);
    @(negedge clk);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_we_i    = we;
    bus.cfg_addr_i  = {cls, rule, fld};
    bus.cfg_wdata_i = wd;
    #1;
    check({tag, ".gnt"}, {63'd0, bus.cfg_gnt_o}, 64'd1);
    @(negedge clk);
    bus.cfg_req_i = 1'b0;
    bus.cfg_we_i  = 1'b0;
    check({tag, ".rvalid"}, {63'd0, bus.cfg_rvalid_o}, 64'd1);
    check({tag, ".rdata"},  bus.cfg_rdata_o, exp_rd);
    check({tag, ".err"},    {63'd0, bus.cfg_err_o}, {63'd0, exp_err});
    check({tag, ".upd"},    {63'd0, table_update}, {63'd0, exp_upd});
  endtask

  task automatic lookup(input string tag, input logic p, input logic [AW-1:0] a,
                        input logic [2:0] exp);
    pma_attr_t at;
    @(negedge clk);
    bus.lookup_valid_i    = '0;
    bus.lookup_valid_i[p] = 1'b1;
    bus.lookup_addr_i[p]  = a;
    @(negedge clk);
    bus.lookup_valid_i = '0;
    at = bus.lookup_attr_o[p];
    check({tag, ".vld"},  {63'd0, bus.lookup_valid_o[p]}, 64'd1);
    check({tag, ".attr"}, {61'd0, at}, {61'd0, exp});
  endtask

  initial begin
    pma_attr_t at;
    rst                = 1'b1;
    bus.cfg_req_i      = 1'b0;
    bus.cfg_we_i       = 1'b0;
    bus.cfg_addr_i     = '0;
    bus.cfg_wdata_i    = '0;
    bus.lookup_valid_i = '0;
    bus.lookup_addr_i  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.rvalid", {63'd0, bus.cfg_rvalid_o}, 64'd0);
    check("rst.rdata",  bus.cfg_rdata_o, 64'd0);
    check("rst.err",    {63'd0, bus.cfg_err_o}, 64'd0);
    check("rst.gnt",    {63'd0, bus.cfg_gnt_o}, 64'd0);
    check("rst.lvld",   {62'd0, bus.lookup_valid_o}, 64'd0);
    at = bus.lookup_attr_o[0];
    check("rst.attr0",  {61'd0, at}, 64'd0);
    at = bus.lookup_attr_o[1];
    check("rst.attr1",  {61'd0, at}, 64'd0);
    check("rst.upd",    {63'd0, table_update}, 64'd0);
    rst = 1'b0;

    // Reset-loaded contents
    cfg_op("rd_ni0_len",  1'b0, NONIDEM, 3'd0, LEN,  64'd0, 64'h8000_0000, 1'b0, 1'b0);
    cfg_op("rd_ni0_ctrl", 1'b0, NONIDEM, 3'd0, CTRL, 64'd0, 64'd1, 1'b0, 1'b0);
    cfg_op("rd_ni1_ctrl", 1'b0, NONIDEM, 3'd1, CTRL, 64'd0, 64'd0, 1'b0, 1'b0);
    cfg_op("rd_ex1_base", 1'b0, EXEC,    3'd1, BASE, 64'd0, 64'h3_FFFF_F000, 1'b0, 1'b0);
    cfg_op("rd_ca1_base", 1'b0, CACHED,  3'd1, BASE, 64'd0, 64'd0, 1'b0, 1'b0);

    // Lookup boundaries ({cached, exec, nonidem})
    lookup("lk_1000",     1'b0, 34'h0_0000_1000, 3'b001);
    lookup("lk_8000_0000",1'b0, 34'h0_8000_0000, 3'b110);
    lookup("lk_8000_0FFF",1'b1, 34'h0_8000_0FFF, 3'b110);
    lookup("lk_8000_1000",1'b1, 34'h0_8000_1000, 3'b100);
    lookup("lk_7FFF_FFFF",1'b1, 34'h0_7FFF_FFFF, 3'b001);
    lookup("lk_below_top",1'b0, 34'h3_FFFF_EFFF, 3'b000);
    lookup("lk_top",      1'b0, 34'h3_FFFF_FFFF, 3'b010);
    @(negedge clk);
    at = bus.lookup_attr_o[0];
    check("hold.vld",  {63'd0, bus.lookup_valid_o[0]}, 64'd0);
    check("hold.attr", {61'd0, at}, 64'd2);

    // Both ports in one cycle
    @(negedge clk);
    bus.lookup_valid_i   = 2'b11;
    bus.lookup_addr_i[0] = 34'h0_0000_1000;
    bus.lookup_addr_i[1] = 34'h0_8000_0FFF;
    @(negedge clk);
    bus.lookup_valid_i = '0;
    check("dual.vld", {62'd0, bus.lookup_valid_o}, 64'd3);
    at = bus.lookup_attr_o[0];
    check("dual.attr0", {61'd0, at}, 64'd1);
    at = bus.lookup_attr_o[1];
    check("dual.attr1", {61'd0, at}, 64'd6);

    // Moving a region requires en=0
    cfg_op("wr_base_en",  1'b1, NONIDEM, 3'd0, BASE, 64'h1000, 64'd0, 1'b1, 1'b0);
    cfg_op("rd_base_kept",1'b0, NONIDEM, 3'd0, BASE, 64'd0, 64'd0, 1'b0, 1'b0);
    cfg_op("ex0_dis",     1'b1, EXEC, 3'd0, CTRL, 64'd0, 64'd0, 1'b0, 1'b1);
    cfg_op("ex0_base",    1'b1, EXEC, 3'd0, BASE, 64'hFFFF_FFFC_4000_0000, 64'd0, 1'b0, 1'b1);
    cfg_op("ex0_en",      1'b1, EXEC, 3'd0, CTRL, 64'd1, 64'd0, 1'b0, 1'b1);
    cfg_op("ex0_rdbase",  1'b0, EXEC, 3'd0, BASE, 64'd0, 64'h4000_0000, 1'b0, 1'b0);
    cfg_op("ex0_same",    1'b1, EXEC, 3'd0, CTRL, 64'd1, 64'd0, 1'b0, 1'b0);
    lookup("lk_moved",    1'b0, 34'h0_4000_0FFF, 3'b011);
    lookup("lk_old_ex",   1'b1, 34'h0_8000_0000, 3'b100);

    // Lock
    cfg_op("ca2_lock",    1'b1, CACHED, 3'd2, CTRL, 64'd3, 64'd0, 1'b0, 1'b1);
    cfg_op("ca2_wlen",    1'b1, CACHED, 3'd2, LEN,  64'h100, 64'd0, 1'b1, 1'b0);
    cfg_op("ca2_wctrl0",  1'b1, CACHED, 3'd2, CTRL, 64'd0, 64'd0, 1'b1, 1'b0);
    cfg_op("ca2_rdctrl",  1'b0, CACHED, 3'd2, CTRL, 64'd0, 64'd3, 1'b0, 1'b0);

    // Bad addresses
    cfg_op("wr_cls3",     1'b1, 2'd3,    3'd0, CTRL, 64'd1, 64'd0, 1'b1, 1'b0);
    cfg_op("rd_cls3",     1'b0, 2'd3,    3'd0, BASE, 64'd0, 64'd0, 1'b1, 1'b0);
    cfg_op("rd_fld3",     1'b0, NONIDEM, 3'd0, 2'd3, 64'd0, 64'd0, 1'b1, 1'b0);
    cfg_op("rd_rule6",    1'b0, NONIDEM, 3'd6, CTRL, 64'd0, 64'd0, 1'b1, 1'b0);
    cfg_op("wr_rule7",    1'b1, NONIDEM, 3'd7, CTRL, 64'd1, 64'd0, 1'b1, 1'b0);
    cfg_op("wr_rule5",    1'b1, NONIDEM, 3'd5, CTRL, 64'd1, 64'd0, 1'b0, 1'b1);
    cfg_op("rd_rule5",    1'b0, NONIDEM, 3'd5, CTRL, 64'd0, 64'd1, 1'b0, 1'b0);

    // Same-cycle disable and lookup: lookup sees the old table
    @(negedge clk);
    bus.cfg_req_i        = 1'b1;
    bus.cfg_we_i         = 1'b1;
    bus.cfg_addr_i       = {NONIDEM, 3'd0, CTRL};
    bus.cfg_wdata_i      = 64'd0;
    bus.lookup_valid_i   = 2'b10;
    bus.lookup_addr_i[1] = 34'h0_0000_1000;
    @(negedge clk);
    bus.cfg_req_i = 1'b0;
    bus.cfg_we_i  = 1'b0;
    check("sc.err", {63'd0, bus.cfg_err_o}, 64'd0);
    check("sc.upd", {63'd0, table_update}, 64'd1);
    check("sc.vld", {62'd0, bus.lookup_valid_o}, 64'd2);
    at = bus.lookup_attr_o[1];
    check("sc.attr_old", {61'd0, at}, 64'd1);
    @(negedge clk);
    bus.lookup_valid_i = '0;
    check("sc.vld2", {62'd0, bus.lookup_valid_o}, 64'd2);
    at = bus.lookup_attr_o[1];
    check("sc.attr_new", {61'd0, at}, 64'd0);

    // Reprogram, then reset with a response and a lookup in flight
    cfg_op("ni0_move",    1'b1, NONIDEM, 3'd0, BASE, 64'h9000_0000, 64'd0, 1'b0, 1'b1);
    lookup("lk_pre_rst",  1'b0, 34'h0_4000_0000, 3'b010);
    @(negedge clk);
    bus.cfg_req_i        = 1'b1;
    bus.cfg_we_i         = 1'b0;
    bus.cfg_addr_i       = {EXEC, 3'd0, BASE};
    bus.lookup_valid_i   = 2'b01;
    bus.lookup_addr_i[0] = 34'h0_4000_0000;
    rst                  = 1'b1;
    @(negedge clk);
    bus.cfg_req_i      = 1'b0;
    bus.lookup_valid_i = '0;
    check("mr.rvalid", {63'd0, bus.cfg_rvalid_o}, 64'd0);
    check("mr.lvld",   {62'd0, bus.lookup_valid_o}, 64'd0);
    at = bus.lookup_attr_o[0];
    check("mr.attr0",  {61'd0, at}, 64'd0);
    rst = 1'b0;
    cfg_op("mr_ni0_base", 1'b0, NONIDEM, 3'd0, BASE, 64'd0, 64'd0, 1'b0, 1'b0);
    cfg_op("mr_ni0_ctrl", 1'b0, NONIDEM, 3'd0, CTRL, 64'd0, 64'd1, 1'b0, 1'b0);
    cfg_op("mr_ex0_base", 1'b0, EXEC,    3'd0, BASE, 64'd0, 64'h8000_0000, 1'b0, 1'b0);
    cfg_op("mr_ca2_ctrl", 1'b0, CACHED,  3'd2, CTRL, 64'd0, 64'd0, 1'b0, 1'b0);
    cfg_op("mr_ni5_ctrl", 1'b0, NONIDEM, 3'd5, CTRL, 64'd0, 64'd0, 1'b0, 1'b0);
    lookup("mr_lk_1000",  1'b0, 34'h0_0000_1000, 3'b001);
    lookup("mr_lk_ex",    1'b1, 34'h0_8000_0FFF, 3'b110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
